// File: rtl/lab3_pkg.sv
// ---------------------------------------------------------------------------
// lab3_pkg
// Shared definitions for the instruction encoder and the decoder bench.
//   INSTR_W            : instruction word width, {op_code, a, b}
//   OP_LSB/A_LSB/B_LSB : bit offsets of each field inside the word
//   state_t            : encoder FSM state encoding (ST_IDLE..ST_DONE)
//   SWEEP_LAST         : final word of an automatic sweep
// ---------------------------------------------------------------------------
package lab3_pkg;

    localparam int INSTR_W = 12;
    localparam int OP_LSB  = 8;
    localparam int A_LSB   = 4;
    localparam int B_LSB   = 0;

    localparam logic [INSTR_W-1:0] SWEEP_LAST = '1;

    // Explicit values so the decoder bench can decode a probed state directly
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_HOLD       = 3'd1,
        ST_SWEEP_WAIT = 3'd2,
        ST_SWEEP_EMIT = 3'd3,
        ST_DONE       = 3'd4
    } state_t;

endpackage

// File: rtl/instr_encoder_tick_gen.sv
// ---------------------------------------------------------------------------
// tick_gen
// Down-counter producing a one-cycle tick every STEP_DIV cycles.
//   clk     in  system clock
//   reset   in  synchronous, active-high; clears the count
//   restart in  reloads the count to STEP_DIV-1
//   tick    out high for one cycle when the count reaches zero
// ---------------------------------------------------------------------------
module tick_gen #(
    parameter int STEP_DIV = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int CW = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;

    logic [CW-1:0] r_count;

    // Count STEP_DIV-1 down to 0, then reload; a restart pulls the count
    // back to the top so the next tick is a full period away.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (restart || (r_count == '0)) begin
            r_count <= CW'(STEP_DIV - 1);
        end else begin
            r_count <= r_count - CW'(1);
        end
    end

    assign tick = (r_count == '0);

endmodule

// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
// Packs operand/opcode switches into {op_code, a, b} and presents it to the
// decoder over valid/ready, either one word per load strobe (manual mode) or
// stepping through every word 0x000..0xFFF (sweep mode).
//   clk, reset    : clock, synchronous active-high reset
//   a, b, op_code : switch inputs, sampled only on a manual capture
//   load          : single-cycle capture strobe
//   counter_mode  : 1 = sweep, 0 = manual
//   out_ready     : decoder accepts the word when out_valid & out_ready
//   out_valid     : instr_code holds a valid word
//   instr_code    : {op_code, a, b}
//   busy          : FSM is outside IDLE
//   sweep_done    : sticky, last sweep word accepted
//   overrun       : sticky, a load arrived while a word was still pending
// ---------------------------------------------------------------------------
module instr_encoder
    import lab3_pkg::*;
#(
    parameter int DATA_W   = 4,
    parameter int OP_W     = 4,
    parameter int STEP_DIV = 50_000_000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [DATA_W-1:0]          a,
    input  logic [DATA_W-1:0]          b,
    input  logic [OP_W-1:0]            op_code,
    input  logic                       load,
    input  logic                       counter_mode,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [OP_W+2*DATA_W-1:0]   instr_code,
    output logic                       busy,
    output logic                       sweep_done,
    output logic                       overrun
);

    state_t             r_state;
    state_t             w_nextState;
    logic [INSTR_W-1:0] r_word;
    logic [INSTR_W-1:0] r_counter;
    logic               r_sweepDone;
    logic               r_overrun;

    logic w_xfer;
    logic w_tick;
    logic w_capture;
    logic w_clearCount;
    logic w_stepCount;
    logic w_setDone;
    logic w_setOverrun;
    logic w_restart;

    // out_valid comes from the state register only, so w_xfer has no path
    // back from out_ready into out_valid.
    assign w_xfer = out_valid & out_ready;

    tick_gen #(
        .STEP_DIV (STEP_DIV)
    ) u_tickGen (
        .clk     (clk),
        .reset   (reset),
        .restart (w_restart),
        .tick    (w_tick)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic plus the one-cycle datapath controls for each edge.
    // A word leaving SWEEP_EMIT always finishes its handshake before any
    // mode change is honoured, so there is never a partial retract.
    always_comb begin
        w_nextState  = r_state;
        w_capture    = 1'b0;
        w_clearCount = 1'b0;
        w_stepCount  = 1'b0;
        w_setDone    = 1'b0;
        w_setOverrun = 1'b0;
        w_restart    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (counter_mode) begin
                    w_clearCount = 1'b1;
                    w_nextState  = ST_SWEEP_EMIT;
                end else if (load) begin
                    w_capture   = 1'b1;
                    w_nextState = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (w_xfer) begin
                    if (load) begin
                        w_capture = 1'b1;
                    end else begin
                        w_nextState = ST_IDLE;
                    end
                end else if (load) begin
                    w_setOverrun = 1'b1;
                end
            end
            ST_SWEEP_EMIT: begin
                if (w_xfer) begin
                    if (r_counter == SWEEP_LAST) begin
                        w_setDone   = 1'b1;
                        w_nextState = ST_DONE;
                    end else if (!counter_mode) begin
                        w_nextState = ST_IDLE;
                    end else begin
                        w_stepCount = 1'b1;
                        w_restart   = 1'b1;
                        w_nextState = ST_SWEEP_WAIT;
                    end
                end
            end
            ST_SWEEP_WAIT: begin
                if (!counter_mode) begin
                    w_nextState = ST_IDLE;
                end else if (w_tick) begin
                    w_nextState = ST_SWEEP_EMIT;
                end
            end
            ST_DONE: begin
                if (!counter_mode) begin
                    w_nextState = ST_IDLE;
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Datapath: manual word, sweep counter and the two sticky flags.
    // Fields are placed by the package offsets so the decoder agrees on layout.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_word      <= '0;
            r_counter   <= '0;
            r_sweepDone <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_capture) begin
                r_word[OP_LSB +: OP_W]  <= op_code;
                r_word[A_LSB +: DATA_W] <= a;
                r_word[B_LSB +: DATA_W] <= b;
            end
            if (w_clearCount) begin
                r_counter   <= '0;
                r_sweepDone <= 1'b0;
            end else if (w_stepCount) begin
                r_counter <= r_counter + INSTR_W'(1);
            end
            if (w_setDone) begin
                r_sweepDone <= 1'b1;
            end
            if (w_setOverrun) begin
                r_overrun <= 1'b1;
            end
        end
    end

    // Outputs decoded from the registered state only
    always_comb begin
        out_valid  = 1'b0;
        instr_code = r_word;
        busy       = (r_state != ST_IDLE);
        case (r_state)
            ST_HOLD: begin
                out_valid = 1'b1;
            end
            ST_SWEEP_EMIT: begin
                out_valid  = 1'b1;
                instr_code = r_counter;
            end
            default: begin
                out_valid = 1'b0;
            end
        endcase
    end

    assign sweep_done = r_sweepDone;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_instr_encoder.sv
// ---------------------------------------------------------------------------
// tb_instr_encoder
// Directed bench for instr_encoder with STEP_DIV=4. Inputs change on the
// falling edge and outputs are checked on the falling edge, away from the
// active rising edge. A posedge monitor counts handshakes and scores the
// sweep sequence.
// ---------------------------------------------------------------------------
module tb_instr_encoder;
    import lab3_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  a;
    logic [3:0]  b;
    logic [3:0]  op_code;
    logic        load;
    logic        counter_mode;
    logic        out_ready;
    logic        out_valid;
    logic [11:0] instr_code;
    logic        busy;
    logic        sweep_done;
    logic        overrun;

    int testsRun      = 0;
    int failCount     = 0;
    int xferCount     = 0;
    int cycleCount    = 0;
    int sweepMon      = 0;
    int sweepCount    = 0;
    int sweepErrs     = 0;
    int sweepExp      = 0;
    int lastXferCycle = 0;
    int minGap        = 1_000_000;

    instr_encoder #(
        .DATA_W   (4),
        .OP_W     (4),
        .STEP_DIV (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .a            (a),
        .b            (b),
        .op_code      (op_code),
        .load         (load),
        .counter_mode (counter_mode),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .instr_code   (instr_code),
        .busy         (busy),
        .sweep_done   (sweep_done),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    // Handshake monitor: counts every transfer and, while a sweep is being
    // scored, checks word order and the spacing between accepted words.
    always @(posedge clk) begin
        cycleCount <= cycleCount + 1;
        if (!reset && out_valid && out_ready) begin
            xferCount <= xferCount + 1;
            if (sweepMon != 0) begin
                if (int'(instr_code) != sweepExp) begin
                    sweepErrs <= sweepErrs + 1;
                end
                if (sweepCount > 0 && (cycleCount - lastXferCycle) < minGap) begin
                    minGap <= cycleCount - lastXferCycle;
                end
                sweepExp      <= sweepExp + 1;
                sweepCount    <= sweepCount + 1;
                lastXferCycle <= cycleCount;
            end
        end
    end

    // Hard stop in case a wait is ever left unbounded
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's worth of inputs, then move to the next falling edge
    task automatic applyStimulus(input logic [3:0] opv, input logic [3:0] av, input logic [3:0] bv,
                                 input logic ld, input logic rdy, input logic mode);
        op_code      = opv;
        a            = av;
        b            = bv;
        load         = ld;
        out_ready    = rdy;
        counter_mode = mode;
        @(negedge clk);
    endtask

    initial begin
        int  x0;
        int  found;
        int  anyValid;

        reset = 1'b1;
        applyStimulus(4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("reset_valid",     32'(out_valid),  32'h0);
        checkOutput("reset_code",      32'(instr_code), 32'h0);
        checkOutput("reset_busy",      32'(busy),       32'h0);
        checkOutput("reset_sweepDone", 32'(sweep_done), 32'h0);
        checkOutput("reset_overrun",   32'(overrun),    32'h0);
        reset = 1'b0;

        // Manual word with the decoder ready: one cycle of valid
        applyStimulus(4'hA, 4'h3, 4'h5, 1'b1, 1'b1, 1'b0);
        checkOutput("manual_valid", 32'(out_valid),  32'h1);
        checkOutput("manual_code",  32'(instr_code), 32'hA35);
        checkOutput("manual_busy",  32'(busy),       32'h1);
        applyStimulus(4'hA, 4'h3, 4'h5, 1'b0, 1'b1, 1'b0);
        checkOutput("manual_validLow", 32'(out_valid), 32'h0);
        checkOutput("manual_idle",     32'(busy),      32'h0);

        // Back-pressure: word held stable for 5 cycles, one transfer total
        x0 = xferCount;
        applyStimulus(4'hA, 4'h3, 4'h5, 1'b1, 1'b0, 1'b0);
        checkOutput("bp_valid", 32'(out_valid),  32'h1);
        checkOutput("bp_code",  32'(instr_code), 32'hA35);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(4'h1, 4'h1, 4'h1, 1'b0, 1'b0, 1'b0);
            checkOutput("bp_holdValid", 32'(out_valid),  32'h1);
            checkOutput("bp_holdCode",  32'(instr_code), 32'hA35);
        end
        applyStimulus(4'h1, 4'h1, 4'h1, 1'b0, 1'b1, 1'b0);
        checkOutput("bp_validLow", 32'(out_valid),       32'h0);
        checkOutput("bp_xferOnce", 32'(xferCount - x0),  32'h1);
        checkOutput("bp_noOverrun", 32'(overrun),        32'h0);

        // Overrun, then a load on the transfer cycle
        applyStimulus(4'h1, 4'h2, 4'h3, 1'b1, 1'b0, 1'b0);
        checkOutput("ovr_code", 32'(instr_code), 32'h123);
        applyStimulus(4'h4, 4'h5, 4'h6, 1'b1, 1'b0, 1'b0);
        checkOutput("ovr_flag",     32'(overrun),    32'h1);
        checkOutput("ovr_wordKept", 32'(instr_code), 32'h123);
        checkOutput("ovr_valid",    32'(out_valid),  32'h1);
        applyStimulus(4'h7, 4'h8, 4'h9, 1'b1, 1'b1, 1'b0);
        checkOutput("simul_valid", 32'(out_valid),  32'h1);
        checkOutput("simul_code",  32'(instr_code), 32'h789);
        applyStimulus(4'h7, 4'h8, 4'h9, 1'b0, 1'b1, 1'b0);
        checkOutput("simul_validLow", 32'(out_valid), 32'h0);
        checkOutput("ovr_sticky",     32'(overrun),   32'h1);

        // Full sweep: every word once, in order, spaced by the divider
        sweepMon = 1;
        applyStimulus(4'hF, 4'hF, 4'hF, 1'b1, 1'b1, 1'b1);
        checkOutput("sweep_firstCode", 32'(instr_code), 32'h000);
        for (int i = 0; i < 30000 && !sweep_done; i++) begin
            applyStimulus(4'hF, 4'hF, 4'hF, 1'b0, 1'b1, 1'b1);
        end
        checkOutput("sweep_done",   32'(sweep_done), 32'h1);
        checkOutput("sweep_count",  32'(sweepCount), 32'd4096);
        checkOutput("sweep_order",  32'(sweepErrs),  32'h0);
        checkOutput("sweep_gap",    32'(minGap >= 4), 32'h1);
        checkOutput("sweep_validLow", 32'(out_valid), 32'h0);
        checkOutput("sweep_stateDone", 32'(dut.r_state), 32'(ST_DONE));
        sweepMon = 0;
        x0 = xferCount;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b1);
        end
        checkOutput("done_noValid", 32'(xferCount - x0), 32'h0);
        checkOutput("done_busy",    32'(busy),           32'h1);
        applyStimulus(4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("done_exitIdle",  32'(busy),       32'h0);
        checkOutput("done_stickyDone", 32'(sweep_done), 32'h1);

        // Abort while 0x010 is pending: it still transfers, then IDLE
        applyStimulus(4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b1);
        checkOutput("abort_doneCleared", 32'(sweep_done), 32'h0);
        found = 0;
        for (int i = 0; i < 500; i++) begin
            if (out_valid && instr_code == 12'h010) begin
                found = 1;
                break;
            end
            applyStimulus(4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b1);
        end
        checkOutput("abort_reach010", 32'(found), 32'h1);
        x0 = xferCount;
        applyStimulus(4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("abort_stillValid", 32'(out_valid),  32'h1);
        checkOutput("abort_stillCode",  32'(instr_code), 32'h010);
        applyStimulus(4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("abort_xfer",     32'(xferCount - x0), 32'h1);
        checkOutput("abort_validLow", 32'(out_valid),      32'h0);
        checkOutput("abort_idle",     32'(busy),           32'h0);
        anyValid = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
            if (out_valid) anyValid++;
        end
        checkOutput("abort_quiet", 32'(anyValid), 32'h0);

        // Reset mid-sweep, then a fresh sweep restarts from 0x000
        found = 0;
        applyStimulus(4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 100; i++) begin
            if (out_valid && instr_code == 12'h003) begin
                found = 1;
                break;
            end
            applyStimulus(4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b1);
        end
        checkOutput("rst_reach003", 32'(found), 32'h1);
        reset = 1'b1;
        applyStimulus(4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b1);
        checkOutput("rst_valid",     32'(out_valid),  32'h0);
        checkOutput("rst_code",      32'(instr_code), 32'h0);
        checkOutput("rst_busy",      32'(busy),       32'h0);
        checkOutput("rst_sweepDone", 32'(sweep_done), 32'h0);
        checkOutput("rst_overrun",   32'(overrun),    32'h0);
        reset = 1'b0;
        applyStimulus(4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b1);
        checkOutput("rst_restartValid", 32'(out_valid),  32'h1);
        checkOutput("rst_restartCode",  32'(instr_code), 32'h000);
        applyStimulus(4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b1);
        checkOutput("rst_stepWait", 32'(out_valid), 32'h0);
        applyStimulus(4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
